sb_pattern_detect: RTL and testbench
====================================

Name: sb_pattern_detect

Overview:
- Receive-side partner of the sideband pattern generator. It watches 64-bit words from the sideband deserializer and looks for the 64-UI alternating clock pattern.
- It produces the `i_rx_sb_pattern_samp_done` indication the generator waits on, and reports a timeout if the pattern is never found.

Parameters:
- PATTERN, 64'hAAAA_AAAA_AAAA_AAAA, expected sideband pattern word.
- ALLOW_INVERTED, 1, when 1 also accept ~PATTERN (pattern sampled one UI shifted).
- MATCH_COUNT, 2, consecutive matching valid words required for detection (range 1..15).
- TIMEOUT_CYCLES, 8000, i_clk cycles allowed in SEARCH before timeout (>=2); counter width = $clog2(TIMEOUT_CYCLES).

Ports:
- i_clk  input  1  sideband clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start_pattern_req  input  1  one-cycle pulse; starts (or restarts) a search.
- i_deser_data  input  64  deserialized sideband word.
- i_deser_valid  input  1  i_deser_data valid this cycle.
- o_rx_sb_pattern_samp_done  output  1  one-cycle pulse, pattern detected.
- o_pattern_detected  output  1  sticky level, set on detection, cleared by next start or reset.
- o_pattern_inverted  output  1  sticky; 1 if detection was made on ~PATTERN words.
- o_pattern_detect_time_out  output  1  one-cycle pulse, search timed out.
- o_searching  output  1  high while in SEARCH.

Behaviour:
- Reset: one clock, i_clk; reset is asynchronous and active-low on i_rst_n.
  - All outputs are 0, state IDLE, match and timeout counters 0.
  - Reset mid-search aborts the search with no done or timeout pulse.
- States: IDLE, SEARCH, DONE, TIMEOUT. All outputs are registered.
- IDLE:
  - i_start_pattern_req=1 -> SEARCH; clear counters, o_pattern_detected and o_pattern_inverted.
  - Data is ignored in IDLE.
- SEARCH, o_searching=1:
  - A word "matches" if i_deser_valid=1 and i_deser_data==PATTERN.
  - When ALLOW_INVERTED=1, a word also matches if i_deser_data==~PATTERN.
  - A run is a sequence of consecutive matching words of the same polarity.
  - A valid word that does not match, or that matches the opposite polarity, restarts the run:
    - match counter = 1 if it matches the other polarity, else 0;
    - the run polarity is updated to that word's polarity.
  - Cycles with i_deser_valid=0 neither advance nor break a run.
  - The timeout counter increments every SEARCH cycle.
  - Detection: at the edge sampling the MATCH_COUNT-th consecutive match -> DONE. The done pulse is high in the following cycle (1-cycle latency from the sampling edge).
  - Timeout: at the edge where the timeout counter equals TIMEOUT_CYCLES-1 without detection -> TIMEOUT.
  - Simultaneous detection and timeout on the same edge: detection wins, no timeout pulse.
  - i_start_pattern_req=1 while in SEARCH restarts the search: counters cleared, state stays SEARCH, no pulse.
- DONE (one cycle):
  - o_rx_sb_pattern_samp_done=1.
  - o_pattern_detected set to 1, o_pattern_inverted set to the run polarity.
  - Next state is IDLE, or SEARCH if i_start_pattern_req=1 in this cycle.
- TIMEOUT (one cycle):
  - o_pattern_detect_time_out=1.
  - Next state is IDLE, or SEARCH if i_start_pattern_req=1.
- Sticky outputs hold in IDLE until the next start or reset.
- Counter widths: the match counter is 4 bits and saturates. The timeout counter never wraps, because state leaves SEARCH at the terminal count.

Test Plan:
- Normal detection: reset 10 cycles, start pulse, then two valid words 64'hAAAA_AAAA_AAAA_AAAA on consecutive cycles -> o_rx_sb_pattern_samp_done pulses exactly 1 cycle, the cycle after the second word's sampling edge; o_pattern_detected=1, o_pattern_inverted=0, o_searching=0.
- Broken run: A…A, 64'h0, A…A, A…A (all valid) -> no done after the first A; done only after the fourth word. Inserting valid=0 bubbles between the two final A words still yields done.
- Inverted pattern: ALLOW_INVERTED=1, words 64'h5555_5555_5555_5555 x2 -> done, o_pattern_inverted=1. With ALLOW_INVERTED=0, the same stimulus with TIMEOUT_CYCLES=20 -> timeout pulse at cycle 20 after start, no done. Mixed A…A then 5…5 -> no detection until a second consecutive 5…5.
- Timeout: TIMEOUT_CYCLES=20, random non-matching data -> o_pattern_detect_time_out pulses once, 20 cycles after start; o_pattern_detected stays 0. Second match landing on the terminal cycle -> done pulse only.
- Restart and reset: start, one matching word, start pulse again, one matching word -> no done (run cleared); a further match -> done. Async i_rst_n low mid-search -> all outputs 0 immediately, no pulses after release.

Source files
------------

// File: rtl/sb_pattern_detect.sv
// sb_pattern_detect
// Receive-side sideband pattern detector. Watches deserialized 64-bit
// sideband words for the alternating clock pattern (optionally its one-UI
// shifted inverse), signals the generator once enough consecutive words
// matched, and flags a timeout when the pattern never shows up.
module sb_pattern_detect #(
  parameter logic [63:0] PATTERN        = 64'hAAAA_AAAA_AAAA_AAAA,
  parameter bit          ALLOW_INVERTED = 1'b1,
  parameter int          MATCH_COUNT    = 2,
  parameter int          TIMEOUT_CYCLES = 8000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start_pattern_req,
  input  logic [63:0] i_deser_data,
  input  logic        i_deser_valid,
  output logic        o_rx_sb_pattern_samp_done,
  output logic        o_pattern_detected,
  output logic        o_pattern_inverted,
  output logic        o_pattern_detect_time_out,
  output logic        o_searching
);

  // Timeout counter is just wide enough for the terminal value.
  localparam int              TW           = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]   TO_LAST      = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      MATCH_TARGET = 4'(MATCH_COUNT);
  localparam logic [3:0]      MATCH_SAT    = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_DONE,
    ST_TIMEOUT
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    match_cnt_q, match_cnt_d;   // length of the current run
  logic          run_inv_q, run_inv_d;       // polarity of the current run (1 = ~PATTERN)
  logic [TW-1:0] to_cnt_q, to_cnt_d;         // SEARCH cycles elapsed
  logic          done_q, done_d;
  logic          detected_q, detected_d;
  logic          inverted_q, inverted_d;
  logic          time_out_q, time_out_d;
  logic          searching_q, searching_d;

  logic          word_is_pat;
  logic          word_is_inv;
  logic [3:0]    run_cnt_nxt;
  logic          run_inv_nxt;
  logic          run_hit;

  // Classify the incoming word and work out where the run would go if
  // this cycle were an ordinary SEARCH cycle.
  always_comb begin
    word_is_pat = i_deser_valid && (i_deser_data == PATTERN);
    word_is_inv = ALLOW_INVERTED && i_deser_valid && (i_deser_data == ~PATTERN);
    run_cnt_nxt = match_cnt_q;
    run_inv_nxt = run_inv_q;
    if (word_is_pat || word_is_inv) begin
      if ((match_cnt_q != 4'd0) && (run_inv_q == word_is_inv)) begin
        // Same polarity extends the run; saturate rather than wrap.
        run_cnt_nxt = (match_cnt_q == MATCH_SAT) ? MATCH_SAT : match_cnt_q + 4'd1;
      end else begin
        // First match, or a polarity flip: this word starts a fresh run.
        run_cnt_nxt = 4'd1;
        run_inv_nxt = word_is_inv;
      end
    end else if (i_deser_valid) begin
      // A valid non-matching word breaks the run; bubbles do not.
      run_cnt_nxt = 4'd0;
    end
    run_hit = (run_cnt_nxt >= MATCH_TARGET);
  end

  // Next-state and next-output logic; every output is registered so the
  // pulses line up with the state they describe.
  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    run_inv_d   = run_inv_q;
    to_cnt_d    = to_cnt_q;
    detected_d  = detected_q;
    inverted_d  = inverted_q;
    done_d      = 1'b0;
    time_out_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Incoming data is ignored until a search is requested.
        if (i_start_pattern_req) begin
          state_d     = ST_SEARCH;
          match_cnt_d = 4'd0;
          run_inv_d   = 1'b0;
          to_cnt_d    = '0;
          detected_d  = 1'b0;
          inverted_d  = 1'b0;
        end
      end

      ST_SEARCH: begin
        if (i_start_pattern_req) begin
          // Restart in place: the word in this cycle does not count.
          match_cnt_d = 4'd0;
          run_inv_d   = 1'b0;
          to_cnt_d    = '0;
        end else if (run_hit) begin
          // Detection takes priority over a coincident terminal count.
          state_d     = ST_DONE;
          done_d      = 1'b1;
          detected_d  = 1'b1;
          inverted_d  = run_inv_nxt;
          match_cnt_d = 4'd0;
          run_inv_d   = 1'b0;
          to_cnt_d    = '0;
        end else if (to_cnt_q == TO_LAST) begin
          state_d     = ST_TIMEOUT;
          time_out_d  = 1'b1;
          match_cnt_d = 4'd0;
          run_inv_d   = 1'b0;
          to_cnt_d    = '0;
        end else begin
          match_cnt_d = run_cnt_nxt;
          run_inv_d   = run_inv_nxt;
          to_cnt_d    = to_cnt_q + TW'(1);
        end
      end

      ST_DONE, ST_TIMEOUT: begin
        // Single-cycle report states; a start here chains straight into SEARCH.
        if (i_start_pattern_req) begin
          state_d     = ST_SEARCH;
          match_cnt_d = 4'd0;
          run_inv_d   = 1'b0;
          to_cnt_d    = '0;
          detected_d  = 1'b0;
          inverted_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    searching_d = (state_d == ST_SEARCH);
  end

  // State and output registers; reset aborts any search silently.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      match_cnt_q <= 4'd0;
      run_inv_q   <= 1'b0;
      to_cnt_q    <= '0;
      done_q      <= 1'b0;
      detected_q  <= 1'b0;
      inverted_q  <= 1'b0;
      time_out_q  <= 1'b0;
      searching_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      run_inv_q   <= run_inv_d;
      to_cnt_q    <= to_cnt_d;
      done_q      <= done_d;
      detected_q  <= detected_d;
      inverted_q  <= inverted_d;
      time_out_q  <= time_out_d;
      searching_q <= searching_d;
    end
  end

  assign o_rx_sb_pattern_samp_done = done_q;
  assign o_pattern_detected        = detected_q;
  assign o_pattern_inverted        = inverted_q;
  assign o_pattern_detect_time_out = time_out_q;
  assign o_searching               = searching_q;

endmodule

// File: tb/tb_sb_pattern_detect.sv
// Bench for sb_pattern_detect. Two instances share one stimulus stream:
// dut 0 accepts the inverted pattern, dut 1 does not; both use a 20-cycle
// timeout. Expected pulses go into a queue when stimulus is issued and a
// monitor on the falling edge matches every observed pulse against it.
module tb_sb_pattern_detect;

  localparam logic [63:0] PA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] PI = 64'h5555_5555_5555_5555;
  localparam logic [63:0] PZ = 64'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        valid = 1'b0;
  logic [63:0] data = '0;

  logic a_done, a_det, a_inv, a_to, a_srch;
  logic b_done, b_det, b_inv, b_to, b_srch;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int dut;
    bit is_to;
    int cyc;
    bit inv;
  } exp_t;

  exp_t exp_q[$];

  sb_pattern_detect #(
    .PATTERN(64'hAAAA_AAAA_AAAA_AAAA), .ALLOW_INVERTED(1'b1),
    .MATCH_COUNT(2), .TIMEOUT_CYCLES(20)
  ) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start_pattern_req(start),
    .i_deser_data(data), .i_deser_valid(valid),
    .o_rx_sb_pattern_samp_done(a_done), .o_pattern_detected(a_det),
    .o_pattern_inverted(a_inv), .o_pattern_detect_time_out(a_to),
    .o_searching(a_srch)
  );

  sb_pattern_detect #(
    .PATTERN(64'hAAAA_AAAA_AAAA_AAAA), .ALLOW_INVERTED(1'b0),
    .MATCH_COUNT(2), .TIMEOUT_CYCLES(20)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start_pattern_req(start),
    .i_deser_data(data), .i_deser_valid(valid),
    .o_rx_sb_pattern_samp_done(b_done), .o_pattern_detected(b_det),
    .o_pattern_inverted(b_inv), .o_pattern_detect_time_out(b_to),
    .o_searching(b_srch)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end else begin
      $display("ok   %s value=%0h (cycle %0d)", nm, act, cyc);
    end
  endfunction

  function automatic void expect_ev(int d, bit is_to, int c, bit inv);
    exp_t e;
    e.dut = d;
    e.is_to = is_to;
    e.cyc = c;
    e.inv = inv;
    exp_q.push_back(e);
  endfunction

  // Drive one cycle of stimulus just after the rising edge; c reports the
  // cycle index, so a word driven at c is sampled by the edge closing it and
  // any resulting pulse is observed while cyc == c+1.
  task automatic drv(input bit s, input bit v, input logic [63:0] d, output int c);
    @(posedge clk);
    #1;
    start = s;
    valid = v;
    data = d;
    c = cyc;
  endtask

  task automatic idle(input int n);
    int c;
    repeat (n) drv(1'b0, 1'b0, PA, c);
  endtask

  // Monitor: every pulse must match the oldest pending expectation for that
  // instance; expectations whose cycle has passed are reported as missing.
  always @(negedge clk) begin
    logic [1:0] dn;
    logic [1:0] tn;
    logic [1:0] iv;
    int idx;
    exp_t e;
    dn = {b_done, a_done};
    tn = {b_to, a_to};
    iv = {b_inv, a_inv};
    for (int d = 0; d < 2; d++) begin
      if (dn[d] || tn[d]) begin
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
          if (idx < 0 && exp_q[i].dut == d) idx = i;
        end
        checks++;
        if (idx < 0) begin
          failures++;
          $display("FAIL unexpected_pulse dut%0d cycle=%0d done=%0b timeout=%0b required=no pulse",
                   d, cyc, dn[d], tn[d]);
        end else begin
          e = exp_q[idx];
          exp_q.delete(idx);
          if (e.cyc != cyc || tn[d] != e.is_to || dn[d] == e.is_to ||
              (!e.is_to && iv[d] != e.inv)) begin
            failures++;
            $display("FAIL pulse dut%0d actual cycle=%0d done=%0b timeout=%0b inv=%0b required cycle=%0d timeout=%0b inv=%0b",
                     d, cyc, dn[d], tn[d], iv[d], e.cyc, e.is_to, e.inv);
          end else begin
            $display("ok   pulse dut%0d cycle=%0d %s inv=%0b", d, cyc, e.is_to ? "timeout" : "done", iv[d]);
          end
        end
      end
    end
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_pulse dut%0d actual=none required %s at cycle %0d",
                 exp_q[i].dut, exp_q[i].is_to ? "timeout" : "done", exp_q[i].cyc);
        exp_q.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int t0;
    logic [63:0] r;

    // Reset: all outputs low.
    repeat (10) @(posedge clk);
    #1;
    chk("reset_outputs_a", {a_done, a_det, a_inv, a_to, a_srch}, 0);
    chk("reset_outputs_b", {b_done, b_det, b_inv, b_to, b_srch}, 0);
    rst_n = 1'b1;
    idle(3);

    // Normal detection: two A words right after start.
    drv(1, 0, PA, t0);
    drv(0, 1, PA, t);
    chk("searching_a", a_srch, 1);
    drv(0, 1, PA, t);
    expect_ev(0, 0, t + 1, 0);
    expect_ev(1, 0, t + 1, 0);
    idle(3);
    chk("normal_detected_a", a_det, 1);
    chk("normal_inverted_a", a_inv, 0);
    chk("normal_searching_a", a_srch, 0);
    chk("normal_detected_b", b_det, 1);
    idle(5);
    chk("sticky_detected_a", a_det, 1);

    // Broken run: A, 0, A, A.
    drv(1, 0, PA, t0);
    drv(0, 1, PA, t);
    drv(0, 1, PZ, t);
    drv(0, 1, PA, t);
    drv(0, 1, PA, t);
    expect_ev(0, 0, t + 1, 0);
    expect_ev(1, 0, t + 1, 0);
    idle(4);

    // Broken run with bubbles before the final A.
    drv(1, 0, PA, t0);
    drv(0, 1, PA, t);
    chk("start_clears_detected_a", a_det, 0);
    drv(0, 1, PZ, t);
    drv(0, 1, PA, t);
    drv(0, 0, PA, t);
    drv(0, 0, PA, t);
    drv(0, 1, PA, t);
    expect_ev(0, 0, t + 1, 0);
    expect_ev(1, 0, t + 1, 0);
    idle(4);

    // Inverted pattern: dut 0 detects, dut 1 times out 20 cycles after start.
    drv(1, 0, PA, t0);
    expect_ev(1, 1, t0 + 21, 0);
    drv(0, 1, PI, t);
    drv(0, 1, PI, t);
    expect_ev(0, 0, t + 1, 1);
    idle(25);
    chk("inv_detected_a", a_det, 1);
    chk("inv_inverted_a", a_inv, 1);
    chk("inv_detected_b", b_det, 0);

    // Mixed polarity: A then 5,5 detects only on the second 5.
    drv(1, 0, PA, t0);
    expect_ev(1, 1, t0 + 21, 0);
    drv(0, 1, PA, t);
    drv(0, 1, PI, t);
    drv(0, 1, PI, t);
    expect_ev(0, 0, t + 1, 1);
    idle(25);
    chk("mixed_inverted_a", a_inv, 1);

    // Timeout on non-matching data.
    drv(1, 0, PA, t0);
    expect_ev(0, 1, t0 + 21, 0);
    expect_ev(1, 1, t0 + 21, 0);
    for (int i = 0; i < 24; i++) begin
      r = {$urandom, $urandom};
      r[7:0] = 8'h00;
      drv(0, 1, r, t);
    end
    idle(2);
    chk("timeout_detected_a", a_det, 0);
    chk("timeout_detected_b", b_det, 0);

    // Second match sampled on the terminal edge: done only.
    drv(1, 0, PA, t0);
    idle(18);
    drv(0, 1, PA, t);
    drv(0, 1, PA, t);
    chk("terminal_alignment", t, t0 + 20);
    expect_ev(0, 0, t0 + 21, 0);
    expect_ev(1, 0, t0 + 21, 0);
    idle(5);
    chk("terminal_detected_a", a_det, 1);

    // Restart clears the run.
    drv(1, 0, PA, t0);
    drv(0, 1, PA, t);
    drv(1, 0, PA, t);
    drv(0, 1, PA, t);
    drv(0, 1, PA, t);
    expect_ev(0, 0, t + 1, 0);
    expect_ev(1, 0, t + 1, 0);
    idle(25);

    // Asynchronous reset just before the detecting edge.
    drv(1, 0, PA, t0);
    drv(0, 1, PA, t);
    chk("pre_reset_searching_a", a_srch, 1);
    drv(0, 1, PA, t);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_a", {a_done, a_det, a_inv, a_to, a_srch}, 0);
    chk("async_reset_b", {b_done, b_det, b_inv, b_to, b_srch}, 0);
    idle(2);
    rst_n = 1'b1;
    idle(30);
    chk("post_reset_idle_a", {a_det, a_srch}, 0);

    idle(3);
    chk("expectations_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
